sine_osc_ctrl: RTL
==================

# sine_osc_ctrl

Sine oscillator sequencer placed directly upstream of the Taylor-series ALU. On each sample strobe it advances a phase accumulator and reduces the phase to a first-quadrant argument. It then issues one sine or cosine request to the ALU, waits for the result, applies the quadrant sign and emits one Q2.16 sample per strobe.

## Interface
- PHASE_W, 24, phase accumulator width (≥18)
- TIMEOUT, 255, maximum cycles waited for `alu_calc_done` before aborting
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- sample_stb  in  1  one-cycle sample-period strobe
- phase_inc  in  PHASE_W  unsigned phase increment per strobe
- overrun_clr  in  1  clears sticky `overrun`/`timeout_err`
- alu_do_calc  out  1  one-cycle request to ALU
- alu_func_sel  out  3  `ALU_FUNC_SIN` or `ALU_FUNC_COS`
- alu_x  out  18  signed Q2.16 argument, range [0, π/2)
- alu_calc_done  in  1  ALU result strobe
- alu_result  in  18  signed Q2.16 ALU result, valid with `alu_calc_done`
- sample_out  out  18  signed Q2.16 sample, held until next sample
- sample_valid  out  1  one-cycle strobe with new `sample_out`
- busy  out  1  high whenever the FSM is not IDLE
- overrun  out  1  sticky: strobe arrived while busy
- timeout_err  out  1  sticky: ALU did not answer within TIMEOUT

## Operation
- Reset values: all outputs 0, phase 0, state IDLE, watchdog 0.
- Phase: on every `sample_stb` (any state) `phase <= phase + phase_inc`, modulo 2^PHASE_W. The pre-increment value is captured as `ph` only when IDLE.
- Reduction: `q = ph[PHASE_W-1:PHASE_W-2]`; `f` = next 16 bits, unsigned Q0.16.
- `alu_x = (f × PI_2)[33:16]`, where PI_2 = 18'h1921F. The product is 16×18 unsigned, 34 bits wide, and the result is truncated.
- Function by quadrant:
  - q=0: sin, sign +
  - q=1: cos, sign +
  - q=2: sin, sign −
  - q=3: cos, sign −
- Negation is two's complement on 18 bits.
- FSM states: IDLE → REDUCE → ISSUE → WAIT → POST → IDLE.
  - IDLE: on `sample_stb`, capture `ph` and go to REDUCE.
  - REDUCE: register `alu_x`, `alu_func_sel` and the sign flag.
  - ISSUE: `alu_do_calc`=1 for exactly one cycle; clear the watchdog.
  - WAIT: on `alu_calc_done`, latch `alu_result` and go to POST. If the watchdog reaches TIMEOUT, set `timeout_err` and go to IDLE without emitting a sample.
  - POST: apply sign (and clamp, see Configuration), update `sample_out`, pulse `sample_valid`, go to IDLE.
- `alu_x` and `alu_func_sel` are held stable from REDUCE until the next REDUCE.
- `sample_stb` while not IDLE:
  - phase still advances (pitch preserved);
  - no request is issued and the sample is dropped;
  - `overrun` is set.
- `alu_calc_done` outside WAIT is ignored.
- `overrun_clr` has priority over a simultaneous set.
- Reset mid-operation: immediate return to IDLE, `alu_do_calc` deasserts asynchronously, and any pending sample is discarded.

## Timing
- Stimulus is `sample_stb` at cycle 0, starting from IDLE.
- Cycle 1 is REDUCE; cycle 2 is ISSUE, with `alu_do_calc` high.
- `alu_calc_done` at cycle N produces `sample_valid` at cycle N+1.
- Total latency is ALU latency + 3 cycles.
- `busy` is high from cycle 1 through POST inclusive.
- Back-to-back strobes are legal when spaced ≥ ALU latency + 4 cycles.

## Configuration
- `SINE_OSC_CLAMP_EN` defined: `alu_result` is clamped to [−18'h10000, +18'h10000] before sign application. This absorbs Taylor-truncation overshoot above 1.0.
- `SINE_OSC_CLAMP_EN` undefined: `alu_result` is passed through unmodified; 18-bit negation wraps.

## Structure
- `globals.vh` holds `ALU_FUNC_SIN` (3'd0), `ALU_FUNC_COS` (3'd1), `Q16_ONE` (18'h10000) and `Q16_PI_2` (18'h1921F).
- Sub-module `osc_phase_acc` holds the phase register, the increment and the capture-on-IDLE logic.
- The FSM, reduction multiplier and sign/clamp logic stay in the top module.

## Test plan
- **Single request:** ALU model with 30-cycle latency; `phase_inc`=24'h100000, one strobe from phase 0.
  - Required: `alu_x`=0, SIN, one `alu_do_calc` at cycle 2.
  - Required: `sample_valid` at cycle 33 with `sample_out` equal to the model result.
- **Quadrant sign:** ph = 24'h800000 gives q=2, `alu_x`=0, SIN. With model result 18'h00100, required `sample_out` is 18'h3FF00.
- **Overrun:** second strobe during WAIT.
  - Required: no second `alu_do_calc`, `overrun`=1, phase advanced twice.
  - Required: `overrun_clr` returns `overrun` to 0.
- **Timeout:** model never answers.
  - Required: `timeout_err`=1 and `busy`=0 after TIMEOUT+3 cycles, no `sample_valid`.
  - Required: the next strobe is served normally.
- **Clamp:** q=3 with model result 18'h10040.
  - With `SINE_OSC_CLAMP_EN`: `sample_out`=18'h30000.
  - Without it: `sample_out`=18'h2FFC0.
- **Reset mid-WAIT:** assert reset low.
  - Required: `alu_do_calc`, `sample_valid`, `busy` and `sample_out` all 0 immediately.
  - Required: a late `alu_calc_done` after release produces no sample.

Source files
------------

// File: rtl/sine_osc_ctrl_pkg.sv
// Shared constants, state encoding and argument-reduction helper for sine_osc_ctrl.
// These constants are the ALU function codes and Q2.16 values that both sides of the ALU interface rely on.
package sine_osc_ctrl_pkg;

    localparam logic [2:0]  ALU_FUNC_SIN = 3'd0;
    localparam logic [2:0]  ALU_FUNC_COS = 3'd1;
    localparam logic [17:0] Q16_ONE      = 18'h10000;
    localparam logic [17:0] Q16_PI_2     = 18'h1921F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_ISSUE,
        ST_WAIT,
        ST_POST
    } oscState_e;

    // Scale a Q0.16 quadrant fraction to a Q2.16 angle in [0, pi/2); truncating.
    function automatic logic [17:0] reduceArg(input logic [15:0] frac);
        logic [33:0] prod;
        prod = {18'd0, frac} * {16'd0, Q16_PI_2};
        return prod[33:16];
    endfunction

endpackage

// File: rtl/sine_osc_ctrl_phase_acc.sv
// Phase accumulator for sine_osc_ctrl: advances on every strobe and snapshots
// the top 18 phase bits (quadrant + fraction) when the sequencer accepts a sample.
module osc_phase_acc #(
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_stb,
    input  logic               capture,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [17:0]        ph
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [17:0]        ph_q, ph_d;

    always_comb begin
        phase_d = phase_q;
        ph_d    = ph_q;
        if (sample_stb) begin
            phase_d = phase_q + phase_inc;
        end
        // The sample belongs to the phase as it stood at the strobe, hence the pre-increment value
        if (capture) begin
            ph_d = phase_q[PHASE_W-1 -: 18];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            ph_q    <= '0;
        end else begin
            phase_q <= phase_d;
            ph_q    <= ph_d;
        end
    end

    assign ph = ph_q;

endmodule

// File: rtl/sine_osc_ctrl.sv
// Sine oscillator sequencer: phase accumulate, quadrant reduce, one ALU request per strobe, sign the result.
// Optional macro SINE_OSC_CLAMP_EN clamps the ALU result to [-1.0, +1.0] before sign application.
module sine_osc_ctrl #(
    parameter int PHASE_W = 24,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_stb,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               overrun_clr,
    output logic               alu_do_calc,
    output logic [2:0]         alu_func_sel,
    output logic [17:0]        alu_x,
    input  logic               alu_calc_done,
    input  logic [17:0]        alu_result,
    output logic [17:0]        sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    import sine_osc_ctrl_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    oscState_e   state_q, state_d;
    logic [17:0] aluX_q, aluX_d;
    logic [2:0]  funcSel_q, funcSel_d;
    logic        signNeg_q, signNeg_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [17:0] sampleOut_q, sampleOut_d;
    logic        overrun_q, overrun_d;
    logic        timeoutErr_q, timeoutErr_d;
    logic [17:0] ph;

    osc_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk        (clk),
        .reset      (reset),
        .sample_stb (sample_stb),
        .capture    (sample_stb && (state_q == ST_IDLE)),
        .phase_inc  (phase_inc),
        .ph         (ph)
    );

    function automatic logic [17:0] shapeSample(input logic [17:0] raw, input logic neg);
        logic signed [17:0] v;
        logic [17:0]        m;
        v = raw;
`ifdef SINE_OSC_CLAMP_EN
        if (v > $signed(Q16_ONE)) begin
            v = $signed(Q16_ONE);
        end else if (v < -$signed(Q16_ONE)) begin
            v = -$signed(Q16_ONE);
        end
`endif
        m = v;
        return neg ? (18'd0 - m) : m;
    endfunction

    // The sample is shaped as it is latched so it is already valid during the POST strobe
    always_comb begin
        state_d      = state_q;
        aluX_d       = aluX_q;
        funcSel_d    = funcSel_q;
        signNeg_d    = signNeg_q;
        wdog_d       = wdog_q;
        sampleOut_d  = sampleOut_q;
        overrun_d    = overrun_q;
        timeoutErr_d = timeoutErr_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_stb) begin
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                aluX_d    = reduceArg(ph[15:0]);
                funcSel_d = ph[16] ? ALU_FUNC_COS : ALU_FUNC_SIN;
                signNeg_d = ph[17];
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_calc_done) begin
                    sampleOut_d = shapeSample(alu_result, signNeg_q);
                    state_d     = ST_POST;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeoutErr_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_POST: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sample_stb && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
        if (overrun_clr) begin
            overrun_d    = 1'b0;
            timeoutErr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            aluX_q       <= '0;
            funcSel_q    <= ALU_FUNC_SIN;
            signNeg_q    <= 1'b0;
            wdog_q       <= '0;
            sampleOut_q  <= '0;
            overrun_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aluX_q       <= aluX_d;
            funcSel_q    <= funcSel_d;
            signNeg_q    <= signNeg_d;
            wdog_q       <= wdog_d;
            sampleOut_q  <= sampleOut_d;
            overrun_q    <= overrun_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // State decodes keep the strobes free of an extra register stage and drop them with reset
    assign alu_do_calc  = (state_q == ST_ISSUE);
    assign sample_valid = (state_q == ST_POST);
    assign busy         = (state_q != ST_IDLE);
    assign alu_func_sel = funcSel_q;
    assign alu_x        = aluX_q;
    assign sample_out   = sampleOut_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeoutErr_q;

endmodule
